// File: rtl/dat_read_multi.sv
// dat_read_multi: SD DAT-line receiver for multi-block reads.
// Samples 1, 4 or 8 lanes on sd_clk_en_i strobes, packs bytes little-endian
// into 32-bit words and checks the per-lane CRC16 and end bit of every block.
module dat_read_multi #(
  parameter int MaxBlockBitSize = 12,
  parameter int BlockCountWidth = 16,
  parameter int TimeoutWidth    = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sd_clk_en_i,
  input  logic [7:0]                 dat_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  input  logic [1:0]                 bus_width_i,
  input  logic [TimeoutWidth-1:0]    timeout_i,
  output logic                       data_valid_o,
  output logic [31:0]                data_o,
  output logic [3:0]                 data_be_o,
  output logic                       block_done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       timeout_err_o,
  output logic                       done_o,
  output logic                       busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StDat,
    StCrc,
    StEndBit
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 width_q, width_d;
  logic [MaxBlockBitSize-1:0] size_q, size_d;
  logic [MaxBlockBitSize-1:0] byteCnt_q, byteCnt_d;
  logic [BlockCountWidth-1:0] count_q, count_d;
  logic [BlockCountWidth-1:0] blockCnt_q, blockCnt_d;
  logic [TimeoutWidth-1:0]    toCnt_q, toCnt_d;
  logic [2:0]                 bitCnt_q, bitCnt_d;
  logic [3:0]                 crcCnt_q, crcCnt_d;
  logic [7:0]                 byteSr_q, byteSr_d;
  logic [31:0]                word_q, word_d;
  logic [15:0]                crc_q [8];
  logic [15:0]                crc_d [8];

  logic                       valid_q, valid_d;
  logic [31:0]                data_q, data_d;
  logic [3:0]                 be_q, be_d;
  logic                       blockDone_q, blockDone_d;
  logic                       crcErr_q, crcErr_d;
  logic                       endErr_q, endErr_d;
  logic                       toErr_q, toErr_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;

  logic [7:0]                 laneMask;
  logic [7:0]                 nextByte;
  logic [2:0]                 lastStrobe;
  logic                       crcBad;
  logic                       endBad;
  logic [MaxBlockBitSize-1:0] byteCntInc;
  logic [BlockCountWidth-1:0] blockCntInc;
  logic [TimeoutWidth-1:0]    toCntInc;

  // One serial step of CRC16-CCITT (x^16+x^12+x^5+1), MSB first, no reflection.
  function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    crcStep = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign byteCntInc  = byteCnt_q + 1'b1;
  assign blockCntInc = blockCnt_q + 1'b1;
  assign toCntInc    = toCnt_q + 1'b1;

  // Decode the latched bus width into a lane mask, byte assembly and strobes per byte.
  always_comb begin
    laneMask   = 8'h01;
    lastStrobe = 3'd7;
    nextByte   = {byteSr_q[6:0], dat_i[0]};
    case (width_q)
      2'd1: begin
        laneMask   = 8'h0F;
        lastStrobe = 3'd1;
        nextByte   = {byteSr_q[3:0], dat_i[3:0]};
      end
      2'd2: begin
        laneMask   = 8'hFF;
        lastStrobe = 3'd0;
        nextByte   = dat_i;
      end
      default: ;
    endcase
  end

  // Block error status over active lanes only: nonzero CRC remainder or a low end bit.
  always_comb begin
    crcBad = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (laneMask[l] && (crc_q[l] != 16'h0000)) crcBad = 1'b1;
    end
    endBad = |(~dat_i & laneMask);
  end

  // Next-state and output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    size_d      = size_q;
    count_d     = count_q;
    byteCnt_d   = byteCnt_q;
    blockCnt_d  = blockCnt_q;
    toCnt_d     = toCnt_q;
    bitCnt_d    = bitCnt_q;
    crcCnt_d    = crcCnt_q;
    byteSr_d    = byteSr_q;
    word_d      = word_q;
    crc_d       = crc_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    be_d        = be_q;
    blockDone_d = 1'b0;
    crcErr_d    = 1'b0;
    endErr_d    = 1'b0;
    toErr_d     = 1'b0;
    done_d      = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d    = StWaitStart;
          width_d    = (bus_width_i == 2'd3) ? 2'd0 : bus_width_i;
          size_d     = block_size_i;
          count_d    = block_count_i;
          blockCnt_d = '0;
          toCnt_d    = '0;
          busy_d     = 1'b1;
        end
      end

      StWaitStart: begin
        if (sd_clk_en_i) begin
          if ((dat_i & laneMask) == 8'h00) begin
            state_d   = StDat;
            bitCnt_d  = '0;
            byteCnt_d = '0;
            toCnt_d   = '0;
            word_d    = '0;
            for (int l = 0; l < 8; l++) crc_d[l] = 16'h0000;
          end else begin
            toCnt_d = toCntInc;
            if ((timeout_i != '0) && (toCntInc == timeout_i)) begin
              state_d = StIdle;
              toErr_d = 1'b1;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end

      StDat: begin
        if (sd_clk_en_i) begin
          for (int l = 0; l < 8; l++) begin
            if (laneMask[l]) crc_d[l] = crcStep(crc_q[l], dat_i[l]);
          end
          byteSr_d = nextByte;
          if (bitCnt_q == lastStrobe) begin
            bitCnt_d = '0;
            word_d[{byteCnt_q[1:0], 3'b000} +: 8] = nextByte;
            if (byteCnt_q[1:0] == 2'd3) begin
              valid_d = 1'b1;
              data_d  = word_d;
              be_d    = 4'hF;
              word_d  = '0;
            end
            byteCnt_d = byteCntInc;
            if (byteCntInc == size_q) begin
              state_d  = StCrc;
              crcCnt_d = '0;
            end
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end

      StCrc: begin
        if (sd_clk_en_i) begin
          for (int l = 0; l < 8; l++) begin
            if (laneMask[l]) crc_d[l] = crcStep(crc_q[l], dat_i[l]);
          end
          if ((crcCnt_q == 4'd0) && (size_q[1:0] != 2'd0)) begin
            valid_d = 1'b1;
            data_d  = word_q;
            word_d  = '0;
            case (size_q[1:0])
              2'd1:    be_d = 4'h1;
              2'd2:    be_d = 4'h3;
              default: be_d = 4'h7;
            endcase
          end
          crcCnt_d = crcCnt_q + 1'b1;
          if (crcCnt_q == 4'd15) state_d = StEndBit;
        end
      end

      StEndBit: begin
        if (sd_clk_en_i) begin
          blockDone_d = 1'b1;
          crcErr_d    = crcBad;
          endErr_d    = endBad;
          blockCnt_d  = blockCntInc;
          if (crcBad || endBad || ((count_q != '0) && (blockCntInc == count_q))) begin
            state_d = StIdle;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = StWaitStart;
            toCnt_d = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && abort_i) begin
      state_d     = StIdle;
      valid_d     = 1'b0;
      data_d      = data_q;
      be_d        = be_q;
      blockDone_d = 1'b0;
      crcErr_d    = 1'b0;
      endErr_d    = 1'b0;
      toErr_d     = 1'b0;
      done_d      = 1'b1;
      busy_d      = 1'b0;
    end
  end

  // State, counters, lane CRCs and registered outputs; reset clears all of it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      width_q     <= '0;
      size_q      <= '0;
      count_q     <= '0;
      byteCnt_q   <= '0;
      blockCnt_q  <= '0;
      toCnt_q     <= '0;
      bitCnt_q    <= '0;
      crcCnt_q    <= '0;
      byteSr_q    <= '0;
      word_q      <= '0;
      for (int l = 0; l < 8; l++) crc_q[l] <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      be_q        <= '0;
      blockDone_q <= 1'b0;
      crcErr_q    <= 1'b0;
      endErr_q    <= 1'b0;
      toErr_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      size_q      <= size_d;
      count_q     <= count_d;
      byteCnt_q   <= byteCnt_d;
      blockCnt_q  <= blockCnt_d;
      toCnt_q     <= toCnt_d;
      bitCnt_q    <= bitCnt_d;
      crcCnt_q    <= crcCnt_d;
      byteSr_q    <= byteSr_d;
      word_q      <= word_d;
      crc_q       <= crc_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      be_q        <= be_d;
      blockDone_q <= blockDone_d;
      crcErr_q    <= crcErr_d;
      endErr_q    <= endErr_d;
      toErr_q     <= toErr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign data_valid_o  = valid_q;
  assign data_o        = data_q;
  assign data_be_o     = be_q;
  assign block_done_o  = blockDone_q;
  assign crc_err_o     = crcErr_q;
  assign end_bit_err_o = endErr_q;
  assign timeout_err_o = toErr_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_dat_read_multi.sv
// tb_dat_read_multi: drives random SD read transfers into dat_read_multi and
// compares every clock's outputs against expectations derived from the byte stream.
module tb_dat_read_multi;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        sd_clk_en_i;
  logic [7:0]  dat_i;
  logic        start_i;
  logic        abort_i;
  logic [11:0] block_size_i;
  logic [15:0] block_count_i;
  logic [1:0]  bus_width_i;
  logic [23:0] timeout_i;
  logic        data_valid_o;
  logic [31:0] data_o;
  logic [3:0]  data_be_o;
  logic        block_done_o;
  logic        crc_err_o;
  logic        end_bit_err_o;
  logic        timeout_err_o;
  logic        done_o;
  logic        busy_o;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [3:0]  be;
    logic        blockDone;
    logic        crcErr;
    logic        endErr;
    logic        toErr;
    logic        done;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  logic xferActive = 1'b0;

  dat_read_multi dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sd_clk_en_i(sd_clk_en_i), .dat_i(dat_i),
    .start_i(start_i), .abort_i(abort_i), .block_size_i(block_size_i),
    .block_count_i(block_count_i), .bus_width_i(bus_width_i), .timeout_i(timeout_i),
    .data_valid_o(data_valid_o), .data_o(data_o), .data_be_o(data_be_o),
    .block_done_o(block_done_o), .crc_err_o(crc_err_o), .end_bit_err_o(end_bit_err_o),
    .timeout_err_o(timeout_err_o), .done_o(done_o), .busy_o(busy_o)
  );

  // 100 MHz system clock
  always #5 clk_i = ~clk_i;

  // Safety net in case the run never reaches its summary
  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one clock of inputs, then check what the DUT shows after that edge
  task automatic applyStimulus(input logic en, input logic [7:0] d, input logic st,
                               input logic ab, input exp_t e);
    sd_clk_en_i = en;
    dat_i       = d;
    start_i     = st;
    abort_i     = ab;
    @(negedge clk_i);
    sd_clk_en_i = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    checkOutput("pulses", {data_valid_o, block_done_o, crc_err_o, end_bit_err_o, timeout_err_o, done_o},
                {e.valid, e.blockDone, e.crcErr, e.endErr, e.toErr, e.done});
    if (e.valid) begin
      checkOutput("data", data_o, e.data);
      checkOutput("be", data_be_o, e.be);
    end
    checkOutput("busy", busy_o, xferActive && !e.done);
    if (e.done) xferActive = 1'b0;
  endtask

  // A strobe preceded by a few idle clocks carrying junk on the lines
  task automatic strobe(input logic [7:0] d, input logic ab, input exp_t e);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, '0);
    applyStimulus(1'b1, d, 1'b0, ab, e);
  endtask

  function automatic int laneCount(input logic [1:0] w);
    return (w == 2'd1) ? 4 : (w == 2'd2) ? 8 : 1;
  endfunction

  // CRC16-CCITT as polynomial long division of message * x^16 by 0x11021
  function automatic logic [15:0] crcOf(input bit bits[$]);
    bit          m[$];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    m = bits;
    repeat (16) m.push_back(1'b0);
    for (int i = 0; i < m.size() - 16; i++) begin
      if (m[i]) for (int t = 0; t <= 16; t++) m[i + t] = m[i + t] ^ g[16 - t];
    end
    for (int t = 0; t < 16; t++) r[15 - t] = m[m.size() - 16 + t];
    return r;
  endfunction

  function automatic bq_t randBytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {data_valid_o, data_o, data_be_o, block_done_o, crc_err_o, end_bit_err_o,
                      timeout_err_o, done_o, busy_o}, 64'h0);
  endtask

  // Start a transfer, then scramble the config inputs, which must now be ignored
  task automatic startXfer(input logic [1:0] w, input int size, input int count);
    bus_width_i   = w;
    block_size_i  = 12'(size);
    block_count_i = 16'(count);
    xferActive    = 1'b1;
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0, '0);
    bus_width_i   = 2'($urandom);
    block_size_i  = 12'($urandom);
    block_count_i = 16'($urandom);
  endtask

  // Send one block: idle strobes, start bit, data, 16 CRC bits per lane, end bit
  task automatic sendBlock(input logic [1:0] w, input bq_t bytes, input int idleStrobes,
                           input int flipLane, input int flipBit, input logic badEnd,
                           input logic lastBlock, input int stopAt, input logic doAbort);
    int          lanes, spb, size;
    logic [7:0]  mask, v;
    logic [7:0]  dataStrobes[$];
    logic [15:0] laneCrc [8];
    logic [31:0] words[$];
    bit          laneQ[$];
    exp_t        e;
    logic        expCrcErr;
    lanes = laneCount(w);
    spb   = 8 / lanes;
    mask  = (lanes == 8) ? 8'hFF : (lanes == 4) ? 8'h0F : 8'h01;
    size  = bytes.size();
    foreach (bytes[k]) begin
      for (int s = 0; s < spb; s++) begin
        v = 8'h00;
        if (lanes == 8) v = bytes[k];
        else if (lanes == 4) v[3:0] = (s == 0) ? bytes[k][7:4] : bytes[k][3:0];
        else v[0] = bytes[k][7 - s];
        dataStrobes.push_back(v);
      end
    end
    for (int k = 0; k < size; k++) begin
      if (k % 4 == 0) words.push_back(32'h0);
      words[k / 4] = words[k / 4] | (32'(bytes[k]) << (8 * (k % 4)));
    end
    for (int l = 0; l < 8; l++) begin
      laneQ.delete();
      foreach (dataStrobes[j]) laneQ.push_back(dataStrobes[j][l]);
      laneCrc[l] = crcOf(laneQ);
    end
    if (flipLane >= 0) laneCrc[flipLane][flipBit] = ~laneCrc[flipLane][flipBit];
    expCrcErr = (flipLane >= 0) && (flipLane < lanes);

    for (int i = 0; i < idleStrobes; i++) strobe(mask | 8'($urandom), 1'b0, '0);
    strobe(~mask & 8'($urandom), 1'b0, '0);

    foreach (dataStrobes[j]) begin
      e = '0;
      if ((j + 1) % (4 * spb) == 0) begin
        e.valid = 1'b1;
        e.data  = words[(j + 1) / (4 * spb) - 1];
        e.be    = 4'hF;
      end
      v = (dataStrobes[j] & mask) | (8'($urandom) & ~mask);
      if (j == stopAt) begin
        if (doAbort) begin
          e      = '0;
          e.done = 1'b1;
          strobe(v, 1'b1, e);
        end
        return;
      end
      strobe(v, 1'b0, e);
    end

    for (int c = 0; c < 16; c++) begin
      e = '0;
      if ((c == 0) && (size % 4 != 0)) begin
        e.valid = 1'b1;
        e.data  = words[words.size() - 1];
        e.be    = 4'((1 << (size % 4)) - 1);
      end
      v = 8'($urandom) & ~mask;
      for (int l = 0; l < lanes; l++) v[l] = laneCrc[l][15 - c];
      strobe(v, 1'b0, e);
    end

    v = mask | (8'($urandom) & ~mask);
    if (badEnd) v[0] = 1'b0;
    e           = '0;
    e.blockDone = 1'b1;
    e.crcErr    = expCrcErr;
    e.endErr    = badEnd;
    e.done      = lastBlock | expCrcErr | badEnd;
    strobe(v, 1'b0, e);
  endtask

  initial begin
    bq_t        q;
    exp_t       e;
    logic [1:0] w;
    int         size, cnt, errKind, fl;

    rst_ni        = 1'b0;
    sd_clk_en_i   = 1'b0;
    dat_i         = 8'hFF;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    block_size_i  = '0;
    block_count_i = '0;
    bus_width_i   = '0;
    timeout_i     = '0;
    repeat (3) @(negedge clk_i);
    checkAllZero("reset");
    rst_ni = 1'b1;

    $display("[TB] 4-bit, 512-byte block of a counting pattern");
    q = {};
    for (int k = 0; k < 512; k++) q.push_back(8'(k));
    startXfer(2'd1, 512, 1);
    sendBlock(2'd1, q, 1, -1, 0, 1'b0, 1'b1, -1, 1'b0);

    $display("[TB] 1-bit, 3-byte residual word");
    q = {8'hA5, 8'h5A, 8'hC3};
    startXfer(2'd0, 3, 1);
    sendBlock(2'd0, q, 0, -1, 0, 1'b0, 1'b1, -1, 1'b0);

    $display("[TB] 8-bit, three 8-byte blocks");
    startXfer(2'd2, 8, 3);
    for (int b = 0; b < 3; b++) begin
      q = randBytes(8);
      sendBlock(2'd2, q, $urandom_range(0, 3), -1, 0, 1'b0, b == 2, -1, 1'b0);
    end

    $display("[TB] 4-bit, CRC bit 5 flipped on lane 2");
    startXfer(2'd1, 16, 2);
    q = randBytes(16);
    sendBlock(2'd1, q, 0, 2, 5, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] start-bit timeout of 10 strobes");
    timeout_i = 24'd10;
    startXfer(2'd0, 4, 1);
    for (int i = 1; i <= 10; i++) begin
      e = '0;
      if (i == 10) begin
        e.toErr = 1'b1;
        e.done  = 1'b1;
      end
      strobe(8'hFF, 1'b0, e);
    end

    $display("[TB] end bit error on first block");
    timeout_i = 24'd0;
    startXfer(2'd2, 5, 2);
    q = randBytes(5);
    sendBlock(2'd2, q, 1, -1, 0, 1'b1, 1'b0, -1, 1'b0);

    $display("[TB] randomized transfers");
    timeout_i = 24'd50;
    for (int t = 0; t < 10; t++) begin
      w    = 2'($urandom_range(0, 3));
      size = $urandom_range(1, 13);
      cnt  = $urandom_range(1, 3);
      startXfer(w, size, cnt);
      for (int b = 0; b < cnt; b++) begin
        q       = randBytes(size);
        errKind = $urandom_range(0, 5);
        fl      = (errKind == 0) ? $urandom_range(0, laneCount(w) - 1) : -1;
        sendBlock(w, q, $urandom_range(0, 3), fl, $urandom_range(0, 15), errKind == 1,
                  b == cnt - 1, -1, 1'b0);
        if (errKind <= 1) break;
      end
    end
    timeout_i = 24'd0;

    $display("[TB] start and abort together in idle");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, '0);
    for (int i = 0; i < 4; i++) strobe(8'h00, 1'b0, '0);

    $display("[TB] unbounded block count ended by abort");
    startXfer(2'd1, 6, 0);
    for (int b = 0; b < 3; b++) begin
      q = randBytes(6);
      sendBlock(2'd1, q, 0, -1, 0, 1'b0, 1'b0, -1, 1'b0);
    end
    e      = '0;
    e.done = 1'b1;
    applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1, e);

    $display("[TB] abort mid-data of block 2 on a word boundary");
    startXfer(2'd2, 8, 3);
    q = randBytes(8);
    sendBlock(2'd2, q, 0, -1, 0, 1'b0, 1'b0, -1, 1'b0);
    q = randBytes(8);
    sendBlock(2'd2, q, 0, -1, 0, 1'b0, 1'b0, 3, 1'b1);
    for (int i = 0; i < 6; i++) strobe(8'($urandom), 1'b0, '0);

    $display("[TB] reset in the middle of a transfer");
    startXfer(2'd1, 16, 1);
    q = randBytes(16);
    sendBlock(2'd1, q, 0, -1, 0, 1'b0, 1'b1, 10, 1'b0);
    rst_ni      = 1'b0;
    sd_clk_en_i = 1'b1;
    dat_i       = 8'h00;
    @(negedge clk_i);
    xferActive = 1'b0;
    checkAllZero("midReset");
    @(negedge clk_i);
    checkAllZero("holdReset");
    sd_clk_en_i = 1'b0;
    rst_ni      = 1'b1;
    for (int i = 0; i < 3; i++) strobe(8'h00, 1'b0, '0);

    $display("[TB] recovery transfer after reset");
    startXfer(2'd0, 5, 1);
    q = randBytes(5);
    sendBlock(2'd0, q, 1, -1, 0, 1'b0, 1'b1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
